lane_done_collector: RTL
========================

Name: lane_done_collector

Overview:
- Sits between the per-lane VFU completion outputs and `vinsn_launcher`.
- Replaces the combinational AND of per-lane done flags, which forces lanes to finish in the same cycle. Instead it captures each lane's done/ID independently and grants each lane as soon as it arrives.
- Reports one aligned done per VFU to the launcher once all lanes have finished the same instruction ID.
- Also flags ID disagreement between lanes and excessive completion skew.

Parameters:
- NrLane, core_pkg::NrLane (4): number of lanes collected.
- NrLaneVFU, core_pkg::NrLaneVFU: number of VFUs per lane; one independent collector per VFU.
- MaxSkew, 15: maximum cycles allowed between the first and last lane grant of one instruction.
- SkewCntW, $clog2(MaxSkew+2): skew counter width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- lane_done_i  in  NrLane x NrLaneVFU  per-lane, per-VFU done valid.
- lane_done_id_i  in  NrLane x NrLaneVFU x insn_id_t  ID attached to each lane done.
- lane_done_gnt_o  out  NrLane x NrLaneVFU  grant back to each lane; the lane drops or advances its done on grant.
- vfus_done_o  out  NrLaneVFU  aligned done to the launcher.
- vfus_done_id_o  out  NrLaneVFU x insn_id_t  ID of the aligned done.
- vfus_done_gnt_i  in  NrLaneVFU  launcher accepts the aligned done.
- id_mismatch_o  out  NrLaneVFU  sticky: a lane presented an ID different from the captured ID.
- skew_err_o  out  NrLaneVFU  sticky: skew counter exceeded MaxSkew.

Behaviour:
- One identical, independent collector per VFU index v; collectors never interact. State per collector: `state` ∈ {COLLECT, REPORT}, `arrived[NrLane]`, `cap_id`, `id_valid`, `skew_cnt`.
- Reset (asynchronous, rst_ni=0):
  - state=COLLECT; arrived=0; id_valid=0; cap_id=0; skew_cnt=0.
  - All outputs 0: lane_done_gnt_o=0, vfus_done_o=0, vfus_done_id_o=0, id_mismatch_o=0, skew_err_o=0.
  - Reset asserted mid-collection discards partial progress; ungranted lane dones simply remain pending.
- Reference ID (combinational) in COLLECT:
  - If id_valid=1, ref_id = cap_id.
  - If id_valid=0, ref_id = lane_done_id_i of the lowest-index lane l with lane_done_i[l][v]=1 and arrived[l]=0.
- Grant (combinational, same cycle as request):
  - lane_done_gnt_o[l][v] = (state==COLLECT) & lane_done_i[l][v] & ~arrived[l] & (lane_done_id_i[l][v]==ref_id).
  - No grant is given in REPORT.
  - No grant is given to a lane already arrived; its next done waits for the following instruction.
- On each granted lane l: arrived[l] <= 1. On the first grant (id_valid=0): cap_id <= ref_id, id_valid <= 1.
- Mismatch: in COLLECT, a request with ~arrived[l] and ID != ref_id is not granted, and sets id_mismatch_o[v] <= 1 (sticky until reset). The request remains pending.
- Simultaneous arrivals in one cycle:
  - All matching lanes are granted together.
  - If every lane arrives in one cycle, vfus_done_o rises the next cycle.
- Transition COLLECT→REPORT: when (arrived | this-cycle grants) becomes all-ones, registered.
  - vfus_done_o[v]=1 and vfus_done_id_o[v]=cap_id (or ref_id if captured this cycle) from the following cycle.
  - Latency from last lane grant to vfus_done_o is exactly 1 cycle.
- REPORT:
  - vfus_done_o held high with a stable ID until vfus_done_gnt_i[v]=1.
  - Cycle of grant: next state COLLECT with arrived=0, id_valid=0, skew_cnt=0; vfus_done_o drops the next cycle.
  - Lane dones presented during the grant cycle are not granted; they are granted from the following cycle. Back-to-back throughput is therefore one instruction per 2 cycles minimum.
- Skew counter:
  - In COLLECT with id_valid=1, skew_cnt increments each cycle, saturating at MaxSkew+1. It is 0 otherwise.
  - When skew_cnt reaches MaxSkew+1, skew_err_o[v] <= 1 (sticky). Collection continues normally.
- vfus_done_gnt_i outside REPORT is ignored.
- insn_id_t comparison is full-width equality; there is no wrap handling, since IDs are tags.

Test Plan:
- Aligned completion: all 4 lanes assert done, ID=3, on VFU0 in cycle 0 → all 4 gnt at cycle 0; vfus_done_o[0]=1, ID=3 at cycle 1; launcher gnt at cycle 2 → done_o=0 at cycle 3.
- Skewed completion: lanes 0,1,2,3 assert ID=5 at cycles 0,2,3,7 → each granted in its own cycle; vfus_done_o rises at cycle 8; skew_err_o stays 0.
- Backpressure: hold vfus_done_gnt_i=0 for 5 cycles while lane 0 presents the next ID=6 → done_o/ID=5 stable; lane 0 gnt=0 throughout; lane 0 granted the cycle after the launcher gnt.
- Mismatch: lanes 0–2 ID=2, lane 3 ID=4 → lane 3 never granted; id_mismatch_o[v]=1; no vfus_done_o until lane 3 presents ID=2.
- Skew error with MaxSkew=15: lane 0 at cycle 0, lanes 1–3 at cycle 20 → skew_err_o=1 by cycle 17; done still reported at cycle 21.
- Reset mid-collection: 2 lanes arrived, assert rst_ni=0 → all outputs 0 immediately; after release, re-presenting all 4 dones produces exactly one vfus_done_o.

Source files
------------

// File: rtl/lane_done_collector.sv
// Collects per-lane VFU completions independently and reports one aligned done
// per VFU once every lane has finished the same instruction ID.
module lane_done_collector #(
    parameter int unsigned NrLane    = 4,
    parameter int unsigned NrLaneVFU = 2,
    parameter int unsigned IdWidth   = 4,
    parameter int unsigned MaxSkew   = 15,
    parameter int unsigned SkewCntW  = $clog2(MaxSkew + 2)
) (
    input  logic                                           clk_i,
    input  logic                                           rst_ni,
    input  logic [NrLane-1:0][NrLaneVFU-1:0]               lane_done_i,
    input  logic [NrLane-1:0][NrLaneVFU-1:0][IdWidth-1:0]  lane_done_id_i,
    output logic [NrLane-1:0][NrLaneVFU-1:0]               lane_done_gnt_o,
    output logic [NrLaneVFU-1:0]                           vfus_done_o,
    output logic [NrLaneVFU-1:0][IdWidth-1:0]              vfus_done_id_o,
    input  logic [NrLaneVFU-1:0]                           vfus_done_gnt_i,
    output logic [NrLaneVFU-1:0]                           id_mismatch_o,
    output logic [NrLaneVFU-1:0]                           skew_err_o
);

    typedef logic [IdWidth-1:0] insn_id_t;
    typedef enum logic {COLLECT, REPORT} state_e;

    localparam logic [SkewCntW-1:0] SkewLim = SkewCntW'(MaxSkew + 1);

    for (genvar v = 0; v < NrLaneVFU; v++) begin : g_vfu
        state_e               state_q, state_d;
        logic [NrLane-1:0]    arrived_q, arrived_d;
        logic [NrLane-1:0]    gnt;
        insn_id_t             cap_id_q, cap_id_d, ref_id;
        logic                 id_valid_q, id_valid_d;
        logic                 mism_q, mism_d;
        logic                 skew_err_q, skew_err_d;
        logic [SkewCntW-1:0]  skew_cnt_q, skew_cnt_d, skew_inc;

        // Before the first grant, the lowest pending lane sets the ID everyone must match.
        always_comb begin
            logic found;
            found  = 1'b0;
            ref_id = cap_id_q;
            if (!id_valid_q) begin
                ref_id = '0;
                for (int l = 0; l < NrLane; l++) begin
                    if (!found && lane_done_i[l][v] && !arrived_q[l]) begin
                        ref_id = lane_done_id_i[l][v];
                        found  = 1'b1;
                    end
                end
            end
        end

        always_comb begin
            // NOTE: every variable gets a default first so no path can infer a latch.
            state_d    = state_q;
            arrived_d  = arrived_q;
            cap_id_d   = cap_id_q;
            id_valid_d = id_valid_q;
            mism_d     = mism_q;
            skew_err_d = skew_err_q;
            skew_cnt_d = '0;
            gnt        = '0;
            skew_inc   = (skew_cnt_q == SkewLim) ? SkewLim : skew_cnt_q + SkewCntW'(1);

            if (state_q == COLLECT) begin
                for (int l = 0; l < NrLane; l++) begin
                    if (lane_done_i[l][v] && !arrived_q[l]) begin
                        if (lane_done_id_i[l][v] == ref_id) gnt[l] = 1'b1;
                        else                                mism_d = 1'b1;
                    end
                end
                arrived_d = arrived_q | gnt;
                if (!id_valid_q && (|gnt)) begin
                    cap_id_d   = ref_id;
                    id_valid_d = 1'b1;
                end
                if (id_valid_q) begin
                    skew_cnt_d = skew_inc;
                    if (skew_inc == SkewLim) skew_err_d = 1'b1;
                end
                if (&arrived_d) state_d = REPORT;
            end else begin
                if (vfus_done_gnt_i[v]) begin
                    state_d    = COLLECT;
                    arrived_d  = '0;
                    id_valid_d = 1'b0;
                end
            end
        end

        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_q    <= COLLECT;
                arrived_q  <= '0;
                cap_id_q   <= '0;
                id_valid_q <= 1'b0;
                mism_q     <= 1'b0;
                skew_err_q <= 1'b0;
                skew_cnt_q <= '0;
            end else begin
                state_q    <= state_d;
                arrived_q  <= arrived_d;
                cap_id_q   <= cap_id_d;
                id_valid_q <= id_valid_d;
                mism_q     <= mism_d;
                skew_err_q <= skew_err_d;
                skew_cnt_q <= skew_cnt_d;
            end
        end

        // Grants are combinational, so they are masked while reset is held.
        for (genvar l = 0; l < NrLane; l++) begin : g_gnt
            assign lane_done_gnt_o[l][v] = gnt[l] & rst_ni;
        end

        assign vfus_done_o[v]    = (state_q == REPORT);
        assign vfus_done_id_o[v] = (state_q == REPORT) ? cap_id_q : '0;
        assign id_mismatch_o[v]  = mism_q;
        assign skew_err_o[v]     = skew_err_q;
    end

endmodule
